// File: rtl/counter8_sched.sv
// counter8_sched: two-requester round-robin scheduler driving an 8-bit LOAD/INC/DEC counter sequencer
module counter8_sched (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [3:0] cnt0,
    input  logic [3:0] cnt1,
    output logic       ack0,
    output logic       ack1,
    output logic [2:0] state,
    output logic [7:0] count,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        INC  = 3'b010,
        INC2 = 3'b011,
        DEC  = 3'b100,
        DEC2 = 3'b101
    } st_t;

    st_t        cur, nxt;
    logic       ptr;
    logic [4:0] rem, nxt_rem;
    logic [7:0] data_l, nxt_count;
    logic       nxt_done, grant, last;
    logic [1:0] g_op;
    logic [7:0] g_data;
    logic [3:0] g_cnt;

    assign state = cur;
    assign busy  = cur != IDLE;

    always_comb begin
        ack0      = !reset && cur == IDLE && req0 && (!req1 || !ptr);
        ack1      = !reset && cur == IDLE && req1 && (!req0 || ptr);
        grant     = ack0 || ack1;
        g_op      = ack1 ? op1 : op0;
        g_data    = ack1 ? data1 : data0;
        g_cnt     = ack1 ? cnt1 : cnt0;
        last      = rem == 5'd1;
        nxt       = cur;
        nxt_count = count;
        nxt_rem   = rem;
        nxt_done  = 1'b0;
        case (cur)
            IDLE: if (grant) begin
                nxt      = g_op == 2'b00 ? LOAD : g_op == 2'b01 ? INC : g_op == 2'b10 ? DEC : IDLE;
                nxt_rem  = {g_cnt == 4'd0, g_cnt};
                nxt_done = g_op == 2'b11;
            end
            LOAD: begin
                nxt       = IDLE;
                nxt_count = data_l;
                nxt_done  = 1'b1;
            end
            INC, INC2: begin
                nxt       = last ? IDLE : cur == INC ? INC2 : INC;
                nxt_count = count + 8'd1;
                nxt_rem   = rem - 5'd1;
                nxt_done  = last;
            end
            DEC, DEC2: begin
                nxt       = last ? IDLE : cur == DEC ? DEC2 : DEC;
                nxt_count = count - 8'd1;
                nxt_rem   = rem - 5'd1;
                nxt_done  = last;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur    <= IDLE;
            count  <= 8'h00;
            ptr    <= 1'b0;
            rem    <= 5'd0;
            data_l <= 8'h00;
            done   <= 1'b0;
        end else begin
            cur   <= nxt;
            count <= nxt_count;
            rem   <= nxt_rem;
            done  <= nxt_done;
            if (grant) begin
                ptr    <= ack0;
                data_l <= g_data;
            end
        end
    end
endmodule

// File: doc/counter8_sched.md
COUNTER8_SCHED -- requirements
Module: counter8_sched

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  reset is synchronous and active-high.
REQ-003 req0 / req1  input  1 each  requester N asks for a counter operation; held high until ackN.
REQ-004 op0 / op1  input  2 each  operation code: 00 LOAD, 01 INC, 10 DEC, 11 reserved.
REQ-005 data0 / data1  input  8 each  load value, used for LOAD only.
REQ-006 cnt0 / cnt1  input  4 each  step count for INC/DEC; 0 means 16 steps.
REQ-007 ack0 / ack1  output  1 each  one-cycle grant pulse; op, data and cnt are sampled in this cycle.
REQ-008 state  output  3  current sequencing state code, registered.
REQ-009 count  output  8  counter value, registered.
REQ-010 busy  output  1  high whenever state != IDLE.
REQ-011 done  output  1  one-cycle pulse marking completion of the granted operation.

Function
REQ-012 State encoding SHALL be: IDLE 000, LOAD 001, INC 010, INC2 011, DEC 100, DEC2 101; codes 110/111 unreachable and SHALL recover to IDLE on the next edge.
REQ-013 Grant SHALL occur only in a cycle where state=IDLE and at least one req is high; exactly one ack pulses; ack is combinational from state, req and the priority pointer.
REQ-014 A single active requester SHALL be granted; on a tie the requester named by a 1-bit round-robin pointer wins.
REQ-015 The pointer SHALL reset to 0 and, after every grant, point to the requester not granted.
REQ-016 Grant cycle T: op, data and cnt of the winner SHALL be latched; state becomes the op's first state at T+1.
REQ-017 LOAD: state=LOAD for one cycle (T+1); count <= latched data at the end of T+1.
REQ-018 INC: n steps (n = cnt, or 16 if cnt=0), one per cycle T+1..T+n; state alternates INC, INC2, INC, ... starting with INC; count <= count+1 mod 256 each step (FF wraps to 00).
REQ-019 DEC: same as INC with DEC, DEC2, ... and count <= count-1 mod 256 (00 wraps to FF).
REQ-020 Reserved op 11: acked normally, no execution states, count unchanged; done pulses at T+1.
REQ-021 After the last step, state SHALL be IDLE at T+n+1 with done=1 and count final; done is low in every other cycle.
REQ-022 A new grant MAY occur in the same cycle done is high (back-to-back, no bubble).
REQ-023 req dropped before ack SHALL be treated as withdrawn; req still high in an IDLE cycle after its ack SHALL be treated as a new request.
REQ-024 req, op, data and cnt changes while busy SHALL have no effect; ack0/ack1 SHALL be low while busy.
REQ-025 count SHALL hold its value in IDLE; only LOAD/INC/INC2/DEC/DEC2 modify it.

Reset
REQ-026 With reset high at an edge: state=IDLE, count=00, pointer=0, busy=0, done=0, and any in-progress operation SHALL be discarded without a done pulse.
REQ-027 ack0/ack1 SHALL be forced low during any cycle where reset is high.
REQ-028 reset SHALL take priority over all other inputs, including a simultaneous req.

Verification
REQ-029 After reset, req0 op=00 data0=5A: ack0 at T; state=001 at T+1; state=000, count=5A, done=1 at T+2.
REQ-030 From count=FE, req1 op=01 cnt=3: states 010, 011, 010 at T+1..T+3; count FF, 00, 01; done at T+4 with count=01.
REQ-031 From count=05, op=10 cnt=0: 16 steps alternating 100/101; done at T+17; count=F5.
REQ-032 req0 and req1 high together after reset: ack0 first; ack1 in the cycle done rises; next tie grants req0.
REQ-033 Reset asserted at T+2 of an INC cnt=5: state=000 and count=00 at the next edge; no done pulse follows.
REQ-034 op=11 from count=3C: ack at T, done at T+1, busy never high, count stays 3C.
